// File: rtl/se_cla_acc_pkg.sv
// Shared types and constants for the bit-serial signed accumulator.
// Holds the FSM state enumeration, default widths and the counter-width helper.
package se_cla_acc_pkg;

    localparam int DEF_IN_W  = 27;
    localparam int DEF_ACC_W = 51;
    localparam int DEF_NBITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter must be able to hold every beat index 0..NBITS.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/se_cla_add.sv
// ACC_W-bit adder/subtractor: sum = a +/- (sext(b) << shamt), wrapping modulo 2^ACC_W.
// The second operand is sign-extended from IN_W bits before the shift.
module se_cla_add #(
    parameter int ACC_W = 51,
    parameter int IN_W  = 27,
    parameter int SH_W  = 4
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    input  logic [SH_W-1:0]  shamt,
    input  logic             sub,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] b_sh;
    logic [ACC_W-1:0] b_op;

    assign b_ext = {{(ACC_W-IN_W){b[IN_W-1]}}, b};
    assign b_sh  = b_ext << shamt;

    // Subtraction as a + ~x + 1, folding the +1 into the carry-in.
    assign b_op  = sub ? ~b_sh : b_sh;
    assign sum   = a + b_op + {{(ACC_W-1){1'b0}}, sub};

endmodule

// File: rtl/se_cla_acc.sv
// Bit-serial signed accumulator: one partial sum per input bit position, LSB first,
// weighted by 2^k and added to a bias; the MSB beat is subtracted for signed inputs.
module se_cla_acc
    import se_cla_acc_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int NBITS     = DEF_NBITS,
    parameter int SIGNED_IN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_psum,
    input  logic [ACC_W-1:0] in_bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    localparam int               CNT_W = cnt_width(NBITS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBITS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ACC_W-1:0] acc, acc_n;

    logic             accept;
    logic             first_beat;
    logic [CNT_W-1:0] k;
    logic             sub;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;

    assign in_ready   = (state == DONE) ? out_ready : 1'b1;
    assign accept     = in_valid && in_ready;

    // Any beat accepted outside ACCUM starts a new run: bias is loaded, not added.
    assign first_beat = (state != ACCUM);
    assign k          = first_beat ? '0 : cnt;
    assign add_a      = first_beat ? in_bias : acc;
    assign sub        = (SIGNED_IN != 0) && (k == LAST);

    se_cla_add #(
        .ACC_W (ACC_W),
        .IN_W  (IN_W),
        .SH_W  (CNT_W)
    ) u_add (
        .a     (add_a),
        .b     (in_psum),
        .shamt (k),
        .sub   (sub),
        .sum   (add_sum)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        if (accept) begin
            acc_n = add_sum;
            if (k == LAST) begin
                state_n = DONE;
                cnt_n   = '0;
            end else begin
                state_n = ACCUM;
                cnt_n   = k + CNT_W'(1);
            end
        end else if (state == DONE && out_ready) begin
            state_n = IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = acc;

endmodule

// File: tb/tb_se_cla_acc.sv
// Self-checking bench for se_cla_acc: three instances (NBITS=4 signed, NBITS=4 unsigned,
// NBITS=1 unsigned) driven with directed and random beats against an arithmetic model.
module tb_se_cla_acc;

    localparam int IN_W  = 27;
    localparam int ACC_W = 51;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr       [3];
    logic             in_valid  [3];
    logic             in_ready  [3];
    logic [IN_W-1:0]  in_psum   [3];
    logic [ACC_W-1:0] in_bias   [3];
    logic             out_valid [3];
    logic             out_ready [3];
    logic [ACC_W-1:0] out_sum   [3];
    logic             busy      [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    se_cla_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .NBITS(4), .SIGNED_IN(1)) u_s4 (
        .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_psum(in_psum[0]), .in_bias(in_bias[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(out_sum[0]), .busy(busy[0]));

    se_cla_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .NBITS(4), .SIGNED_IN(0)) u_u4 (
        .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_psum(in_psum[1]), .in_bias(in_bias[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(out_sum[1]), .busy(busy[1]));

    se_cla_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .NBITS(1), .SIGNED_IN(0)) u_u1 (
        .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_psum(in_psum[2]), .in_bias(in_bias[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sum(out_sum[2]), .busy(busy[2]));

    function automatic int nbits_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit signed_of(input int i);
        return (i == 0);
    endfunction

    // Reference: bias + sum(psum_k * 2^k), MSB term negated for signed inputs, mod 2^ACC_W.
    function automatic logic [ACC_W-1:0] model(input logic [ACC_W-1:0] bias,
                                               input logic [IN_W-1:0] ps [16],
                                               input int n, input bit sg);
        longint total;
        longint term;
        total = longint'($signed(bias));
        for (int k = 0; k < n; k++) begin
            term = longint'($signed(ps[k])) * (longint'(1) << k);
            if (sg && k == n - 1) total = total - term;
            else                  total = total + term;
        end
        return total[ACC_W-1:0];
    endfunction

    // Drives nbeats beats on instance i; returns at the negedge after the last accepted beat.
    task automatic run_beats(input int i, input logic [ACC_W-1:0] bias,
                             input logic [IN_W-1:0] ps [16], input int nbeats,
                             input bit gaps, input bit ordy_first);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && k > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid[i] = 1'b0;
                    in_psum[i]  = IN_W'($urandom);
                    in_bias[i]  = ACC_W'({$urandom, $urandom});
                    @(negedge clk);
                end
            end
            in_valid[i]  = 1'b1;
            in_psum[i]   = ps[k];
            in_bias[i]   = (k == 0) ? bias : ACC_W'({$urandom, $urandom});
            out_ready[i] = (k == 0) ? ordy_first : 1'b0;
            @(negedge clk);
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b0;
        in_psum[i]   = IN_W'($urandom);
    endtask

    task automatic consume(input int i);
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks += 4;
            if (out_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]); end
            if (out_sum[i] !== '0)     begin n_fail++; $display("FAIL reset_out_sum[%0d]: got %0h want 0", i, out_sum[i]); end
            if (busy[i] !== 1'b0)      begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
            if (in_ready[i] !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [IN_W-1:0]  ps [16];
        logic [ACC_W-1:0] want;
        for (int k = 0; k < 16; k++) ps[k] = '0;
        for (int k = 0; k < 4; k++) ps[k] = IN_W'(1);

        // Signed: 1 + 2 + 4 - 8 = -1
        run_beats(0, '0, ps, 4, 0, 0);
        want = '1;
        n_checks += 2;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL dir_signed_valid: got %b want 1", out_valid[0]); end
        if (out_sum[0] !== want)   begin n_fail++; $display("FAIL dir_signed_sum: got %0h want %0h", out_sum[0], want); end
        consume(0);
        n_checks += 2;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL dir_consumed_valid: got %b want 0", out_valid[0]); end
        if (busy[0] !== 1'b0)      begin n_fail++; $display("FAIL dir_consumed_busy: got %b want 0", busy[0]); end

        // Unsigned: 1 + 2 + 4 + 8 = 15
        run_beats(1, '0, ps, 4, 0, 0);
        want = ACC_W'(15);
        n_checks += 2;
        if (out_valid[1] !== 1'b1) begin n_fail++; $display("FAIL dir_unsigned_valid: got %b want 1", out_valid[1]); end
        if (out_sum[1] !== want)   begin n_fail++; $display("FAIL dir_unsigned_sum: got %0h want %0h", out_sum[1], want); end
        consume(1);

        // NBITS=1: large bias plus negative psum
        ps[0] = -IN_W'(12345);
        run_beats(2, ACC_W'(64'd5432109876), ps, 1, 0, 0);
        want = ACC_W'(64'd5432097531);
        n_checks += 2;
        if (out_valid[2] !== 1'b1) begin n_fail++; $display("FAIL dir_n1_valid: got %b want 1", out_valid[2]); end
        if (out_sum[2] !== want)   begin n_fail++; $display("FAIL dir_n1_sum: got %0d want %0d", out_sum[2], want); end
        consume(2);

        // NBITS=1: wrap from 2^50-1 + 1 to -2^50
        ps[0] = IN_W'(1);
        run_beats(2, {1'b0, {(ACC_W-1){1'b1}}}, ps, 1, 0, 0);
        want = {1'b1, {(ACC_W-1){1'b0}}};
        n_checks += 1;
        if (out_sum[2] !== want) begin n_fail++; $display("FAIL dir_wrap_sum: got %0h want %0h", out_sum[2], want); end
        consume(2);
    endtask

    task automatic test_random();
        logic [IN_W-1:0]  ps [16];
        logic [ACC_W-1:0] bias;
        logic [ACC_W-1:0] want;
        int               i;
        for (int r = 0; r < 36; r++) begin
            i    = r % 3;
            bias = ACC_W'({$urandom, $urandom});
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 3))
                    0:       ps[k] = {1'b1, {(IN_W-1){1'b0}}};
                    1:       ps[k] = {1'b0, {(IN_W-1){1'b1}}};
                    default: ps[k] = IN_W'($urandom);
                endcase
            end
            want = model(bias, ps, nbits_of(i), signed_of(i));
            run_beats(i, bias, ps, nbits_of(i), 1, 0);
            n_checks += 3;
            if (out_valid[i] !== 1'b1) begin n_fail++; $display("FAIL rand_valid[%0d] run %0d: got %b want 1", i, r, out_valid[i]); end
            if (busy[i] !== 1'b1)      begin n_fail++; $display("FAIL rand_busy[%0d] run %0d: got %b want 1", i, r, busy[i]); end
            if (out_sum[i] !== want)   begin n_fail++; $display("FAIL rand_sum[%0d] run %0d: got %0h want %0h", i, r, out_sum[i], want); end
            consume(i);
        end
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0]  psa [16];
        logic [IN_W-1:0]  psb [16];
        logic [ACC_W-1:0] want_a;
        logic [ACC_W-1:0] want_b;
        for (int k = 0; k < 16; k++) begin
            psa[k] = IN_W'($urandom);
            psb[k] = IN_W'($urandom);
        end
        want_a = model(ACC_W'(64'd777), psa, 4, 1);
        want_b = model(ACC_W'(64'd31337), psb, 4, 1);
        run_beats(0, ACC_W'(64'd777), psa, 4, 0, 0);
        for (int c = 0; c < 3; c++) begin
            in_valid[0] = 1'b1;
            in_psum[0]  = IN_W'($urandom);
            in_bias[0]  = ACC_W'({$urandom, $urandom});
            #1;
            n_checks += 3;
            if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL stall_valid cycle %0d: got %b want 1", c, out_valid[0]); end
            if (in_ready[0] !== 1'b0)  begin n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b want 0", c, in_ready[0]); end
            if (out_sum[0] !== want_a) begin n_fail++; $display("FAIL stall_sum cycle %0d: got %0h want %0h", c, out_sum[0], want_a); end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1;
        n_checks += 1;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL done_in_ready_follows: got %b want 1", in_ready[0]); end
        run_beats(0, ACC_W'(64'd31337), psb, 4, 0, 1);
        n_checks += 2;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", out_valid[0]); end
        if (out_sum[0] !== want_b) begin n_fail++; $display("FAIL b2b_sum: got %0h want %0h", out_sum[0], want_b); end
        consume(0);
    endtask

    task automatic test_clear();
        logic [IN_W-1:0]  ps [16];
        logic [ACC_W-1:0] want;
        for (int k = 0; k < 16; k++) ps[k] = IN_W'($urandom);
        run_beats(0, ACC_W'({$urandom, $urandom}), ps, 3, 0, 0);
        clr[0]      = 1'b1;
        in_valid[0] = 1'b1;
        in_psum[0]  = IN_W'($urandom);
        @(negedge clk);
        clr[0]      = 1'b0;
        in_valid[0] = 1'b0;
        n_checks += 3;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", out_valid[0]); end
        if (busy[0] !== 1'b0)      begin n_fail++; $display("FAIL clr_busy: got %b want 0", busy[0]); end
        if (in_ready[0] !== 1'b1)  begin n_fail++; $display("FAIL clr_in_ready: got %b want 1", in_ready[0]); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks += 1;
            if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL clr_no_result cycle %0d: got %b want 0", c, out_valid[0]); end
        end
        for (int k = 0; k < 16; k++) ps[k] = '0;
        run_beats(0, ACC_W'(64'd100), ps, 4, 0, 0);
        want = ACC_W'(64'd100);
        n_checks += 2;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL clr_fresh_valid: got %b want 1", out_valid[0]); end
        if (out_sum[0] !== want)   begin n_fail++; $display("FAIL clr_fresh_sum: got %0d want %0d", out_sum[0], want); end
        consume(0);
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0]  ps [16];
        logic [ACC_W-1:0] bias;
        logic [ACC_W-1:0] want;
        for (int k = 0; k < 16; k++) ps[k] = IN_W'($urandom);
        run_beats(0, ACC_W'({$urandom, $urandom}), ps, 2, 0, 0);
        rst         = 1'b1;
        clr[0]      = 1'b1;
        in_valid[0] = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        clr[0]      = 1'b0;
        in_valid[0] = 1'b0;
        n_checks += 4;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid[0]); end
        if (out_sum[0] !== '0)     begin n_fail++; $display("FAIL rstmid_sum: got %0h want 0", out_sum[0]); end
        if (busy[0] !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy[0]); end
        if (in_ready[0] !== 1'b1)  begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready[0]); end
        bias = ACC_W'({$urandom, $urandom});
        for (int k = 0; k < 16; k++) ps[k] = IN_W'($urandom);
        want = model(bias, ps, 4, 1);
        run_beats(0, bias, ps, 4, 1, 0);
        n_checks += 2;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_rerun_valid: got %b want 1", out_valid[0]); end
        if (out_sum[0] !== want)   begin n_fail++; $display("FAIL rstmid_rerun_sum: got %0h want %0h", out_sum[0], want); end
        consume(0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clr[i]       = 1'b0;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_psum[i]   = '0;
            in_bias[i]   = '0;
        end
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
